// File: rtl/riscv_hwloop_pkg.sv
// Shared types and constants for the hardware-loop jump controller.
package riscv_hwloop_pkg;

  localparam int N_REGS = 2;
  localparam logic [31:0] CNT_LAST = 32'd1;

  typedef enum logic {
    IDLE,
    PEND
  } hwlp_state_e;

endpackage

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-address and counter comparison.
module riscv_hwloop_match
  import riscv_hwloop_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic [31:0] end_addr_i,
  input  logic [31:0] counter_i,
  output logic        match_o,
  output logic        cont_o,
  output logic        exit_o
);

  logic armed;

  assign armed   = (counter_i != 32'd0);
  assign match_o = pc_valid_i & armed & (pc_i == end_addr_i);
  assign cont_o  = match_o & (counter_i > CNT_LAST);
  assign exit_o  = match_o & (counter_i == CNT_LAST);

endmodule

// File: rtl/riscv_hwloop_jump_ctrl.sv
// Hardware-loop jump controller: end-of-loop detection, jump handshake.
// HWLP_NESTED_EN enables evaluation of loop 1 (outer loop).
module riscv_hwloop_jump_ctrl #(
  parameter int N_REGS = riscv_hwloop_pkg::N_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic              pc_valid_i,
  input  logic [31:0]       hwlp_start_addr_0_i,
  input  logic [31:0]       hwlp_end_addr_0_i,
  input  logic [31:0]       hwlp_counter_0_i,
  input  logic [31:0]       hwlp_start_addr_1_i,
  input  logic [31:0]       hwlp_end_addr_1_i,
  input  logic [31:0]       hwlp_counter_1_i,
  input  logic              flush_i,
  input  logic              jump_ack_i,
  output logic              hwlp_jump_o,
  output logic [31:0]       hwlp_target_o,
  output logic [N_REGS-1:0] hwlp_dec_cnt_o,
  output logic              hwlp_stall_o
);

  import riscv_hwloop_pkg::*;

`ifdef HWLP_NESTED_EN
  localparam logic NESTED = 1'b1;
`else
  localparam logic NESTED = 1'b0;
`endif

  hwlp_state_e       state_q, state_d;
  logic [31:0]       target_q, target_d;
  logic [N_REGS-1:0] dec_q, dec_d;

  logic m0, c0, e0;
  logic m1_raw, c1_raw, e1_raw;
  logic m1, c1, e1;

  riscv_hwloop_match u_match0 (
    .pc_i       (pc_i),
    .pc_valid_i (pc_valid_i),
    .end_addr_i (hwlp_end_addr_0_i),
    .counter_i  (hwlp_counter_0_i),
    .match_o    (m0),
    .cont_o     (c0),
    .exit_o     (e0)
  );

  riscv_hwloop_match u_match1 (
    .pc_i       (pc_i),
    .pc_valid_i (pc_valid_i),
    .end_addr_i (hwlp_end_addr_1_i),
    .counter_i  (hwlp_counter_1_i),
    .match_o    (m1_raw),
    .cont_o     (c1_raw),
    .exit_o     (e1_raw)
  );

  // Loop 1 is masked off entirely when nesting is not built in.
  assign m1 = NESTED & m1_raw;
  assign c1 = NESTED & c1_raw;
  assign e1 = NESTED & e1_raw;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dec_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (c0) begin
          target_d = hwlp_start_addr_0_i;
          dec_d[0] = 1'b1;
          state_d  = PEND;
        end else if (e0 & c1) begin
          target_d = hwlp_start_addr_1_i;
          dec_d[0] = 1'b1;
          dec_d[1] = 1'b1;
          state_d  = PEND;
        end else if (e0) begin
          dec_d[0] = 1'b1;
        end else if (c1 & ~m0) begin
          target_d = hwlp_start_addr_1_i;
          dec_d[1] = 1'b1;
          state_d  = PEND;
        end else if (e1 & ~m0) begin
          dec_d[1] = 1'b1;
        end
      end
      PEND: begin
        if (flush_i | jump_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      dec_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dec_q    <= dec_d;
    end
  end

  assign hwlp_jump_o    = (state_q == PEND);
  assign hwlp_stall_o   = (state_q == PEND);
  assign hwlp_target_o  = target_q;
  assign hwlp_dec_cnt_o = dec_q;

endmodule

// File: tb/tb_riscv_hwloop_jump_ctrl.sv
// Directed and random checks of riscv_hwloop_jump_ctrl against a loop model.
module tb_riscv_hwloop_jump_ctrl;

`ifdef HWLP_NESTED_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pv = 1'b0;
  logic [31:0] sa [2];
  logic [31:0] ea [2];
  logic [31:0] cn [2];
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic        jump, stall;
  logic [31:0] target;
  logic [1:0]  dec;

  int checks = 0;
  int failures = 0;

  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [1:0]  m_dec = '0;

  always #5 clk = ~clk;

  riscv_hwloop_jump_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_i                (pc),
    .pc_valid_i          (pv),
    .hwlp_start_addr_0_i (sa[0]),
    .hwlp_end_addr_0_i   (ea[0]),
    .hwlp_counter_0_i    (cn[0]),
    .hwlp_start_addr_1_i (sa[1]),
    .hwlp_end_addr_1_i   (ea[1]),
    .hwlp_counter_1_i    (cn[1]),
    .flush_i             (flush),
    .jump_ack_i          (ack),
    .hwlp_jump_o         (jump),
    .hwlp_target_o       (target),
    .hwlp_dec_cnt_o      (dec),
    .hwlp_stall_o        (stall)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".jump"}, {31'd0, jump}, {31'd0, m_pend});
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, m_pend});
    chk({tag, ".target"}, target, m_tgt);
    chk({tag, ".dec"}, {30'd0, dec}, {30'd0, m_dec});
  endtask

  // Reference: which loops hit their end, which repeat, where to go.
  task automatic tick(input string tag);
    bit hit [2];
    bit again [2];
    bit nxt_pend;
    logic [1:0] nxt_dec;
    logic [31:0] nxt_tgt;
    nxt_dec = '0;
    nxt_tgt = m_tgt;
    nxt_pend = m_pend;
    for (int k = 0; k < 2; k++) begin
      hit[k] = pv && cn[k] != 0 && pc == ea[k] && (k == 0 || NESTED);
      again[k] = hit[k] && cn[k] >= 2;
    end
    if (m_pend) begin
      if (flush || ack) nxt_pend = 1'b0;
    end else if (hit[0]) begin
      nxt_dec[0] = 1'b1;
      if (again[0]) begin
        nxt_pend = 1'b1;
        nxt_tgt = sa[0];
      end else if (again[1]) begin
        nxt_dec[1] = 1'b1;
        nxt_pend = 1'b1;
        nxt_tgt = sa[1];
      end
    end else if (hit[1]) begin
      nxt_dec[1] = 1'b1;
      if (again[1]) begin
        nxt_pend = 1'b1;
        nxt_tgt = sa[1];
      end
    end
    @(posedge clk);
    #1;
    m_pend = nxt_pend;
    m_tgt = nxt_tgt;
    m_dec = nxt_dec;
    chk_all(tag);
  endtask

  task automatic set_loop(input int k, input logic [31:0] s,
                          input logic [31:0] e, input logic [31:0] c);
    sa[k] = s;
    ea[k] = e;
    cn[k] = c;
  endtask

  task automatic idle_ins();
    pv = 1'b0;
    ack = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    set_loop(0, 32'h0, 32'hFFFF_FFF0, 32'd0);
    set_loop(1, 32'h0, 32'hFFFF_FFF0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b0;

    // Inner loop continue
    set_loop(0, 32'h100, 32'h10C, 32'd3);
    pc = 32'h10C;
    pv = 1'b1;
    tick("inner_cont");
    chk("inner_cont.jump_lit", {31'd0, jump}, 32'd1);
    chk("inner_cont.tgt_lit", target, 32'h100);
    idle_ins();
    ack = 1'b1;
    tick("inner_ack");
    idle_ins();
    tick("inner_idle");

    // Inner loop exit
    cn[0] = 32'd1;
    pc = 32'h10C;
    pv = 1'b1;
    tick("inner_exit");
    chk("inner_exit.dec_lit", {30'd0, dec}, 32'd1);
    idle_ins();
    tick("inner_exit2");

    // Nested shared end
    set_loop(0, 32'h1C0, 32'h200, 32'd1);
    set_loop(1, 32'h1F0, 32'h200, 32'd5);
    pc = 32'h200;
    pv = 1'b1;
    tick("nested");
    chk("nested.dec_lit", {30'd0, dec}, NESTED ? 32'd3 : 32'd1);
    idle_ins();
    ack = 1'b1;
    tick("nested_ack");
    idle_ins();
    tick("nested_idle");

    // Handshake held off, repeat end pcs ignored
    set_loop(0, 32'h100, 32'h10C, 32'd4);
    set_loop(1, 32'h0, 32'hFFFF_FFF0, 32'd0);
    pc = 32'h10C;
    pv = 1'b1;
    tick("hs_det");
    for (int i = 0; i < 4; i++) begin
      pv = i[0];
      tick("hs_hold");
      chk("hs_hold.tgt_lit", target, 32'h100);
    end
    pv = 1'b0;
    ack = 1'b1;
    tick("hs_ack");
    idle_ins();
    tick("hs_drop");
    chk("hs_drop.jump_lit", {31'd0, jump}, 32'd0);

    // Flush and ack together in T+2
    pc = 32'h10C;
    pv = 1'b1;
    tick("fa_det");
    idle_ins();
    tick("fa_t2");
    flush = 1'b1;
    ack = 1'b1;
    tick("fa_t3");
    idle_ins();
    tick("fa_t4");

    // Flush in IDLE has no effect on a registered pulse
    cn[0] = 32'd1;
    pc = 32'h10C;
    pv = 1'b1;
    tick("fi_det");
    idle_ins();
    flush = 1'b1;
    tick("fi_t2");
    flush = 1'b0;

    // Disarmed loops
    set_loop(0, 32'h100, 32'h300, 32'd0);
    set_loop(1, 32'h180, 32'h300, 32'd0);
    pc = 32'h300;
    pv = 1'b1;
    tick("disarmed");
    chk("disarmed.dec_lit", {30'd0, dec}, 32'd0);
    idle_ins();

    // Reset during PEND
    set_loop(0, 32'h400, 32'h41C, 32'd7);
    pc = 32'h41C;
    pv = 1'b1;
    tick("rp_det");
    idle_ins();
    rst = 1'b1;
    #1;
    m_pend = 1'b0;
    m_tgt = '0;
    m_dec = '0;
    chk_all("rp_async");
    rst = 1'b0;
    set_loop(0, 32'h500, 32'h510, 32'd2);
    pc = 32'h510;
    pv = 1'b1;
    tick("rp_after");
    chk("rp_after.jump_lit", {31'd0, jump}, 32'd1);
    idle_ins();
    ack = 1'b1;
    tick("rp_ack");

    // Random traffic over a small address space
    for (int i = 0; i < 400; i++) begin
      sa[0] = $urandom;
      sa[1] = $urandom;
      ea[0] = 32'h100 + 4 * $urandom_range(0, 1);
      ea[1] = 32'h100 + 4 * $urandom_range(0, 1);
      cn[0] = $urandom_range(0, 3);
      cn[1] = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) cn[$urandom_range(0, 1)] = 32'hFFFF_FFFF;
      pc = 32'h100 + 4 * $urandom_range(0, 2);
      pv = $urandom_range(0, 1);
      ack = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_jump_ctrl.md
# riscv_hwloop_jump_ctrl

Hardware-loop jump controller between the hardware-loop register file and the instruction prefetcher. It watches the PC of each instruction leaving the IF stage and compares it against both loops' end addresses and counters. On a match it issues a registered jump request to the loop start address, with a request/acknowledge handshake and a stall toward IF. It also returns one-cycle counter-decrement pulses to the loop register file.

## Interface
Parameters:
- N_REGS, 2, number of hardware loops; fixed at 2, loop 0 is the inner loop.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- pc_i  in  32  PC of the instruction currently leaving IF.
- pc_valid_i  in  1  pc_i is valid and the instruction advances this cycle.
- hwlp_start_addr_0_i / hwlp_end_addr_0_i / hwlp_counter_0_i  in  32 each  loop 0 registers.
- hwlp_start_addr_1_i / hwlp_end_addr_1_i / hwlp_counter_1_i  in  32 each  loop 1 registers.
- flush_i  in  1  branch, exception or debug kill; cancels a pending jump.
- jump_ack_i  in  1  prefetcher has accepted the jump target.
- hwlp_jump_o  out  1  jump request to the prefetcher.
- hwlp_target_o  out  32  jump target; stable while hwlp_jump_o=1.
- hwlp_dec_cnt_o  out  N_REGS  one-cycle decrement pulse per loop.
- hwlp_stall_o  out  1  IF must not advance.

## Operation
- A loop k is armed when counter_k != 0.
- Match_k: pc_valid_i & armed_k & (pc_i == end_addr_k).
- Continue_k: match_k & (counter_k > 1). Exit_k: match_k & (counter_k == 1).
- Decision, evaluated only in state IDLE:
  - If continue_0: jump to start_0 and decrement loop 0.
  - Else if exit_0 & continue_1: jump to start_1 and decrement both loops. This is the nested case with a shared end address.
  - Else if exit_0: decrement loop 0 only, no jump.
  - Else if continue_1 (no match_0): jump to start_1 and decrement loop 1.
  - Else if exit_1: decrement loop 1 only.
- FSM states:
  - IDLE: on any jump decision, go to PEND. A decrement without a jump stays in IDLE.
  - PEND: hwlp_jump_o=1, hwlp_stall_o=1, pc_valid_i ignored.
    - jump_ack_i=1: go to IDLE.
    - flush_i=1: go to IDLE with no ack required; flush has priority over ack in the same cycle.
- Decrements already issued are never rolled back, including on flush.
- Address compare is a full 32-bit equality; no alignment masking.
- Counter compares are unsigned 32-bit.

## Timing
- Reset values: state IDLE, hwlp_jump_o=0, hwlp_target_o=0, hwlp_dec_cnt_o=0, hwlp_stall_o=0.
- Detection in cycle T (IDLE) gives the following in T+1:
  - hwlp_dec_cnt_o pulses for exactly one cycle.
  - On a jump: hwlp_jump_o=1, target registered, stall=1.
- jump_ack_i may arrive in T+1 or later. hwlp_jump_o and stall fall in the cycle after the ack; pc_valid_i is evaluated again from that cycle.
- The prefetcher discards any instruction fetched after the end address once it sees hwlp_jump_o.
- flush_i in IDLE has no effect. A decrement pulse already registered still fires.
- Reset asserted mid-PEND: outputs clear immediately (asynchronous) and the state returns to IDLE.
- Register-file writes during PEND are not tracked. The next decision uses the values present in that cycle.

## Configuration
- HWLP_NESTED_EN defined: both loops are evaluated as above.
- HWLP_NESTED_EN undefined: only loop 0 is evaluated.
  - Loop 1 inputs are ignored.
  - hwlp_dec_cnt_o[1] is tied 0.
  - exit_0 always means fall-through.

## Structure
- Package riscv_hwloop_pkg: FSM state enum (IDLE, PEND), the N_REGS constant, and the counter threshold constant (1).
- Sub-module riscv_hwloop_match, instantiated once per loop: takes pc, pc_valid, end and counter; outputs match, continue and exit.
- The top level holds the priority logic, FSM and output registers.

## Test plan
- Inner loop: start_0=0x100, end_0=0x10C, cnt_0=3; pc 0x10C valid.
  - Required: T+1 jump=1, target=0x100, dec=2'b01.
  - With cnt_0=1: dec=2'b01 and no jump.
- Nested shared end: end_0=end_1=0x200, cnt_0=1, cnt_1=5, start_1=0x1F0; pc 0x200.
  - Required: target=0x1F0, dec=2'b11.
  - Without HWLP_NESTED_EN: dec=2'b01 and no jump.
- Handshake: hold jump_ack_i=0 for 4 cycles after the jump.
  - Required: jump and stall held and target stable throughout.
  - Repeat pc=end pulses during PEND are ignored.
  - Ack in the 5th cycle: jump drops the next cycle.
- Flush vs ack: flush_i and jump_ack_i both high in T+2.
  - Required: jump drops at T+3 and no further decrement.
- Disarmed loops: cnt_0=0 and cnt_1=0 with pc equal to both end addresses.
  - Required: no jump, dec=0.
- Reset mid-PEND: assert rst during PEND.
  - Required: all outputs 0 asynchronously.
  - After release, the first pc=end_0 with cnt_0=2 jumps normally.
